i2s_tx: RTL
===========

Name: i2s_tx

Overview:
- Serialises processed 24-bit mono samples from the effects chain (data + one-cycle DV strobe) into a standard I2S stream for the codec DAC.
- Generates BCLK/LRCLK internally from i_clk.
- Single-entry holding register decouples the DV-strobed sample rate from the serial frame.
- Each sample is duplicated onto the left and right channels.

Parameters:
- BCLK_HALF, 2, i_clk cycles per BCLK half-period (>=1). Default gives 12.288 MHz i_clk -> 3.072 MHz BCLK -> 48 kHz frame.
- SLOT_BITS, 32, BCLK cycles per channel slot (>=25). Frame length is 2*SLOT_BITS.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_data  in  24  signed sample, two's complement; sampled only when i_DV=1
- i_DV  in  1  one-cycle sample strobe
- o_bclk  out  1  serial bit clock
- o_lrclk  out  1  word select; 0=left, 1=right
- o_sdata  out  1  serial data, MSB first
- o_overflow  out  1  sticky; a held sample was overwritten before transmission
- o_underrun  out  1  sticky; a frame started with no new sample held

Behaviour:
- Reset (i_rst_n=0 at posedge i_clk) clears everything to 0, including mid-frame: o_bclk, o_lrclk, o_sdata, o_overflow, o_underrun, div counter, bit counter, hold reg, hold_valid, frame reg. First BCLK rising edge occurs BCLK_HALF cycles after reset release.
- Divider: div_cnt counts 0..BCLK_HALF-1. At terminal count it wraps to 0 and o_bclk toggles.
- Fall event: a 1->0 toggle of o_bclk. All o_sdata/o_lrclk/counter updates happen on the same i_clk edge as a fall event, so data changes on BCLK falling and is stable on rising.
- Bit counter: bit_cnt runs 0..2*SLOT_BITS-1 and increments on each fall event, wrapping to 0.
- Slot and word select: slot index s = bit_cnt mod SLOT_BITS. o_lrclk = (bit_cnt >= SLOT_BITS), registered with bit_cnt.
- Capture: on i_DV=1, hold <= i_data and hold_valid <= 1. If hold_valid was already 1 and the value is not being consumed this cycle, o_overflow <= 1 and the new sample replaces the old one.
- Frame load: occurs on the fall event where bit_cnt wraps to 0.
  - If hold_valid=1: frame <= hold and hold_valid <= 0.
  - If hold_valid=0: frame <= 0 and o_underrun <= 1.
- Simultaneous i_DV and frame load: frame takes the old hold value; the new i_data lands in hold with hold_valid=1; no overflow.
- Serial data, standard I2S: o_sdata = frame[24-s] for s=1..24, else 0. The MSB appears one BCLK after each LRCLK edge. Both channels carry the same frame value.
- States (implicit in bit_cnt): LEFT_PAD(s=0), LEFT_DATA(1..24), LEFT_TAIL(25..SLOT_BITS-1), then the same three for right.
- Latency: from the i_DV capture to the MSB on o_sdata is the remaining cycles to the next frame load plus one BCLK period (2*BCLK_HALF i_clk cycles).
- Sticky flags clear only on reset.

Optional Feature:
- Macro: I2S_TX_LJ_EN.
- Defined: left-justified format. o_sdata = frame[23-s] for s=0..23, else 0. MSB is coincident with the LRCLK edge; the frame load still happens at bit_cnt wrap to 0.
- Undefined: standard I2S timing with the one-BCLK delay, as in Behaviour.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0. o_bclk period = 4 i_clk cycles. o_lrclk period = 256 i_clk cycles, low for first 128.
- i_DV with i_data=24'hA50F3C before frame start -> left and right slots each show bit pattern 1010_0101_0000_1111_0011_1100 on BCLK rising edges, starting at s=1, then 8 zeros. o_overflow=0, o_underrun=0.
- Two i_DV (24'h000001, then 24'h7FFFFF) within one frame, before the load -> next frame transmits 7FFFFF; o_overflow=1 and stays 1.
- No i_DV for a full frame after one sample -> following frame all zeros; o_underrun=1.
- i_DV=24'h123456 on the same cycle as the frame-load fall event -> that frame carries the previous hold value; 123456 is transmitted in the next frame with no overflow.
- Reset asserted at s=10 of the right slot -> next cycle all outputs and flags 0; restart matches scenario 1. With I2S_TX_LJ_EN, scenario 2 has the MSB at s=0.

Source files
------------

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//
// Purpose:
//   Serialises 24-bit mono samples (data + one-cycle DV strobe) into an I2S
//   stream for a codec DAC. BCLK and LRCLK are derived from i_clk. A
//   single-entry holding register decouples the sample strobe from the serial
//   frame. Each sample is sent on both the left and the right channel.
//
// Parameters:
//   BCLK_HALF  i_clk cycles per BCLK half-period (>=1)
//   SLOT_BITS  BCLK cycles per channel slot (>=25); frame = 2*SLOT_BITS bits
//
// Ports:
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_data      24-bit two's complement sample, taken only when i_DV=1
//   i_DV        one-cycle sample strobe
//   o_bclk      serial bit clock
//   o_lrclk     word select (0=left, 1=right)
//   o_sdata     serial data, MSB first
//   o_overflow  sticky: a held sample was overwritten before transmission
//   o_underrun  sticky: a frame started with no new sample held
//
// Handshake:
//   i_DV is a strobe with no back-pressure. A sample is taken on every cycle
//   where i_DV=1; if the hold register still holds an untransmitted sample it
//   is replaced and o_overflow is set.
//
// Configuration:
//   I2S_TX_LJ_EN  defined   -> left-justified format (MSB on the LRCLK edge)
//                 undefined -> standard I2S (MSB one BCLK after LRCLK edge)
//
// The channel/slot sequencing (pad, data, tail for left then right) is
// implicit in bit_cnt_q, so no separate state register is kept.
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int BCLK_HALF = 2,
  parameter int SLOT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_data,
  input  logic        i_DV,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_overflow,
  output logic        o_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_q,        div_d;
  logic             bclk_q,       bclk_d;
  logic [BIT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic             lrclk_q,      lrclk_d;
  logic             sdata_q,      sdata_d;
  logic [23:0]      hold_q,       hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [23:0]      frame_q,      frame_d;
  logic             overflow_q,   overflow_d;
  logic             underrun_q,   underrun_d;

  logic             div_tc;
  logic             fall;
  logic             bit_last;
  logic             load;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_nxt;
  logic [BIT_W-1:0] bit_idx;
  logic             sdata_nxt;

  always_comb begin
    div_tc   = (div_q == DIV_W'(BCLK_HALF - 1));
    // Everything serial moves on the BCLK falling edge so the codec samples
    // stable data on the rising edge.
    fall     = div_tc & bclk_q;
    bit_last = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
    load     = fall & bit_last;
    bit_nxt  = bit_last ? '0 : bit_cnt_q + BIT_W'(1);
    slot_nxt = (bit_nxt >= BIT_W'(SLOT_BITS)) ? bit_nxt - BIT_W'(SLOT_BITS)
                                              : bit_nxt;

    div_d   = div_tc ? '0 : div_q + DIV_W'(1);
    bclk_d  = bclk_q ^ div_tc;

    // Frame value used for the serial bit must be the one loaded on this same
    // edge (matters for the left-justified MSB at slot 0).
    frame_d = frame_q;
    if (load) begin
      frame_d = hold_valid_q ? hold_q : 24'd0;
    end

    sdata_nxt = 1'b0;
    bit_idx   = '0;
`ifdef I2S_TX_LJ_EN
    if (slot_nxt <= BIT_W'(23)) begin
      bit_idx   = BIT_W'(23) - slot_nxt;
      sdata_nxt = frame_d[bit_idx[4:0]];
    end
`else
    if ((slot_nxt >= BIT_W'(1)) && (slot_nxt <= BIT_W'(24))) begin
      bit_idx   = BIT_W'(24) - slot_nxt;
      sdata_nxt = frame_d[bit_idx[4:0]];
    end
`endif

    bit_cnt_d = fall ? bit_nxt : bit_cnt_q;
    lrclk_d   = fall ? (bit_nxt >= BIT_W'(SLOT_BITS)) : lrclk_q;
    sdata_d   = fall ? sdata_nxt : sdata_q;

    // A strobe coinciding with the frame load refills the register the load
    // is emptying, so it is not an overwrite.
    hold_d       = i_DV ? i_data : hold_q;
    hold_valid_d = i_DV ? 1'b1 : (load ? 1'b0 : hold_valid_q);
    overflow_d   = overflow_q | (i_DV & hold_valid_q & ~load);
    underrun_d   = underrun_q | (load & ~hold_valid_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      frame_q      <= '0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      frame_q      <= frame_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sdata    = sdata_q;
  assign o_overflow = overflow_q;
  assign o_underrun = underrun_q;

endmodule
